encrypt_ctrl: RTL
=================

# encrypt_ctrl

Sequencing controller that drives the single-port-write, combinational-read `dat_mem` to perform the Lab 4 LFSR encryption pass. On `start` it fetches three configuration bytes from the memory: preamble length, feedback taps and LFSR seed. It then writes a 64-byte padded and encrypted message into the result region. The output is laid out as preamble, then message, then trailing pad. The block owns every memory address and write-enable line during a run and holds the memory port quiet otherwise.

## Interface
Parameters:
- `W`, 8, data width (matches memory word)
- `ADDR_W`, 8, memory address width
- `MSG_BASE`, 4, first plaintext address
- `MSG_LEN`, 52, plaintext byte count
- `OUT_BASE`, 128, first result address
- `OUT_LEN`, 64, result byte count
- `PRE_MIN`, 7, minimum preamble length
- `PRE_MAX`, 12, maximum preamble length
- `PAD_CHAR`, 8'h20, preamble/pad plaintext byte

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  run request, sampled only in IDLE or DONE
- `raddr`  out  ADDR_W  memory read pointer
- `rdata`  in  W  memory combinational read data
- `waddr`  out  ADDR_W  memory write pointer
- `wdata`  out  W  memory write data
- `wr_en`  out  1  memory write enable
- `busy`  out  1  high from first cycle after accepted start until DONE
- `done`  out  1  high in DONE state, level

## Operation
- States: IDLE, RD_LEN, RD_TAP, RD_SEED, PRE, MSG, PAD, DONE.
- IDLE/DONE: when `start`=1, go to RD_LEN. Otherwise hold. `start` in any other state is ignored.
- RD_LEN: `raddr`=0. Capture `rdata` as preamble length P, clamped:
  - P<PRE_MIN gives PRE_MIN.
  - P>PRE_MAX gives PRE_MAX.
  - Compare the full 8-bit value, unsigned.
- RD_TAP: `raddr`=1. Capture `rdata[4:0]` as taps. Bits [7:5] are ignored.
- RD_SEED: `raddr`=2. Load `rdata[4:0]` into the 5-bit LFSR.
- Write phase: the output counter k runs 0..OUT_LEN-1. Every cycle:
  - `wr_en`=1.
  - `waddr`=OUT_BASE+k.
  - `wdata`=plain ^ {3'b000, lfsr}.
  - LFSR advances: lfsr <= {lfsr[3:0], ^(lfsr & taps)}.
- Keystream order: byte k uses the LFSR value after k advances. Byte 0 uses the seed.
- PRE: plain=PAD_CHAR for k<P.
- MSG: message counter m runs 0..MSG_LEN-1. `raddr`=MSG_BASE+m and plain=`rdata` (same cycle, combinational read).
- PAD: plain=PAD_CHAR for k≥P+MSG_LEN. When P=PRE_MAX=12, PAD is skipped (P+52=64).
- After k=OUT_LEN-1 is written, go to DONE.
- Seed 0: no special handling. The LFSR stays 0 and output equals plaintext.

## Timing
- Reset values:
  - state=IDLE
  - `busy`=0, `done`=0, `wr_en`=0
  - `raddr`=0, `waddr`=0, `wdata`=0
  - counters, taps and LFSR=0
- `wr_en` is forced 0 combinationally whenever `reset`=1.
- Outside write states, `wr_en`=0, `raddr`=0, `waddr`=0 and `wdata`=0.
- Cycle schedule, relative to the edge that samples `start` (edge 0):
  - cycles 1–3: RD_LEN, RD_TAP, RD_SEED
  - cycles 4–67: 64 writes, one per cycle, no gaps
  - cycle 68 onward: `done`=1, `busy`=0
- Total: 68 cycles from start to done.
- `done` stays high until reset or a new `start` (DONE→RD_LEN clears `done` on the next cycle).
- Reset asserted mid-run: the next edge returns to IDLE. No further writes occur. Partial results stay in memory.
- Counters are sized to hold OUT_LEN without wrap. Address sums stay within ADDR_W for the default parameters.

## Test plan
- mem[0]=10, mem[1]=8'h12, mem[2]=8'h01, start pulse -> mem[128]=8'h21, mem[129]=8'h22, mem[130]=8'h25 (keystream 01,02,05). Message byte 0 lands at 138. mem[190..191] are pad bytes. `done` rises exactly 68 cycles after start.
- mem[0]=3 (below min) -> P=7. Preamble at 128..134, plaintext mem[4] encrypted at 135, mem[55] at 186, pad at 187..191.
- mem[0]=20 (above max) -> P=12. Message occupies 140..191. No pad writes. Exactly 64 `wr_en` cycles.
- mem[2]=0 (zero seed), mem[0]=7 -> mem[128..134]=8'h20 and mem[135..186] equal mem[4..55] verbatim.
- Repeat `start` pulses during the write phase -> ignored: 64 writes total, done at cycle 68. A `start` during DONE -> `done` drops, and a second identical run produces identical results.
- Assert `reset` at cycle 30 of a run -> `wr_en` is 0 in that cycle and afterward. State returns to IDLE, `busy`=0, `done`=0. No writes to 158..191.

Source files
------------

// File: rtl/encrypt_ctrl.sv
// rtl/encrypt_ctrl.sv - LFSR encryption pass sequencer for a single-port-write memory
//
// Purpose: on start, read preamble length, taps and seed from mem[0..2], then
// write OUT_LEN encrypted bytes (preamble, message, pad) to OUT_BASE onward.
// Ports:
//   clk, reset    - clock, synchronous active-high reset
//   start         - run request, honoured only in IDLE or DONE
//   raddr / rdata - memory read pointer / combinational read data
//   waddr / wdata - memory write pointer / write data
//   wr_en         - memory write enable (forced low while reset is high)
//   busy / done   - run in progress / run complete (level)
module encrypt_ctrl #(
  parameter int             W        = 8,
  parameter int             ADDR_W   = 8,
  parameter int             MSG_BASE = 4,
  parameter int             MSG_LEN  = 52,
  parameter int             OUT_BASE = 128,
  parameter int             OUT_LEN  = 64,
  parameter int             PRE_MIN  = 7,
  parameter int             PRE_MAX  = 12,
  parameter logic [W-1:0]   PAD_CHAR = 8'h20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] raddr,
  input  logic [W-1:0]      rdata,
  output logic [ADDR_W-1:0] waddr,
  output logic [W-1:0]      wdata,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(OUT_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_LEN, S_RD_TAP, S_RD_SEED, S_PRE, S_MSG, S_PAD, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   pre_len_q, pre_len_d;
  logic [4:0]         taps_q, taps_d;
  logic [4:0]         lfsr_q, lfsr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               in_write;
  logic               k_last;
  logic [W-1:0]       plain;

  assign in_write = (state_q == S_PRE) || (state_q == S_MSG) || (state_q == S_PAD);
  assign k_last   = (k_q == CNT_W'(OUT_LEN - 1));

  // Next-state and datapath update
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    m_d       = m_q;
    pre_len_d = pre_len_q;
    taps_d    = taps_q;
    lfsr_d    = lfsr_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_RD_LEN;
      end
      S_RD_LEN: begin
        // Full-width unsigned clamp before narrowing to the counter width
        if (rdata < W'(PRE_MIN))      pre_len_d = CNT_W'(PRE_MIN);
        else if (rdata > W'(PRE_MAX)) pre_len_d = CNT_W'(PRE_MAX);
        else                          pre_len_d = CNT_W'(rdata);
        state_d = S_RD_TAP;
      end
      S_RD_TAP: begin
        taps_d  = rdata[4:0];
        state_d = S_RD_SEED;
      end
      S_RD_SEED: begin
        lfsr_d  = rdata[4:0];
        k_d     = '0;
        m_d     = '0;
        state_d = S_PRE;
      end
      S_PRE: begin
        if (k_q == pre_len_q - CNT_W'(1)) state_d = S_MSG;
      end
      S_MSG: begin
        m_d = m_q + CNT_W'(1);
        // A maximal preamble fills the region exactly, so PAD is skipped
        if (m_q == CNT_W'(MSG_LEN - 1)) state_d = k_last ? S_DONE : S_PAD;
      end
      S_PAD: begin
        if (k_last) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every write cycle consumes one keystream value
    if (in_write) begin
      k_d    = k_q + CNT_W'(1);
      lfsr_d = {lfsr_q[3:0], ^(lfsr_q & taps_q)};
    end

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      m_q       <= '0;
      pre_len_q <= '0;
      taps_q    <= '0;
      lfsr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      m_q       <= m_d;
      pre_len_q <= pre_len_d;
      taps_q    <= taps_d;
      lfsr_q    <= lfsr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Memory port decode; the message byte flows straight from rdata to wdata
  always_comb begin
    plain = PAD_CHAR;
    raddr = '0;
    unique case (state_q)
      S_RD_TAP:  raddr = ADDR_W'(1);
      S_RD_SEED: raddr = ADDR_W'(2);
      S_MSG: begin
        raddr = ADDR_W'(MSG_BASE) + ADDR_W'(m_q);
        plain = rdata;
      end
      default: raddr = '0;
    endcase

    waddr = in_write ? (ADDR_W'(OUT_BASE) + ADDR_W'(k_q)) : '0;
    wdata = in_write ? (plain ^ {{(W-5){1'b0}}, lfsr_q}) : '0;
    wr_en = in_write && !reset;
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
